// File: rtl/vector_deserializer.sv
// Serial-to-parallel loader: packs a valid/ready element stream into VECTORS x FEATURES
// parallel vectors and holds the frame until the consumer acknowledges it.
module vector_deserializer #(
  parameter int ELEMENT_BITS  = 8,
  parameter int FEATURES      = 4,
  parameter int VECTORS       = 2,
  parameter int ELEM_CNT_BITS = (FEATURES > 1) ? $clog2(FEATURES) : 1,
  parameter int VEC_CNT_BITS  = (VECTORS > 1) ? $clog2(VECTORS) : 1
) (
  input  logic                                     clk,
  input  logic                                     reset_n,
  input  logic                                     start,
  input  logic                                     abort,
  input  logic                                     in_valid,
  input  logic [ELEMENT_BITS-1:0]                  in_data,
  output logic                                     in_ready,
  output logic [VECTORS*FEATURES*ELEMENT_BITS-1:0] out_data,
  output logic                                     out_valid,
  input  logic                                     out_ack,
  output logic                                     done,
  output logic                                     busy
);

  localparam int OUT_W = VECTORS * FEATURES * ELEMENT_BITS;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FILL = 2'd1,
    HOLD = 2'd2
  } state_t;

  state_t                   state_q, state_d;
  logic [ELEM_CNT_BITS-1:0] elem_cnt_q, elem_cnt_d;
  logic [VEC_CNT_BITS-1:0]  vec_cnt_q, vec_cnt_d;
  logic [OUT_W-1:0]         data_q, data_d;
  logic                     done_q, done_d;
  logic                     accept;
  logic                     elem_last;
  logic                     vec_last;

  // abort masks the handshake so an element offered alongside it is never written
  assign accept    = (state_q == FILL) && in_valid && !abort;
  assign elem_last = (elem_cnt_q == ELEM_CNT_BITS'(FEATURES - 1));
  assign vec_last  = (vec_cnt_q == VEC_CNT_BITS'(VECTORS - 1));

  always_comb begin
    state_d    = state_q;
    elem_cnt_d = elem_cnt_q;
    vec_cnt_d  = vec_cnt_q;
    data_d     = data_q;
    done_d     = 1'b0;

    for (int v = 0; v < VECTORS; v++) begin
      for (int f = 0; f < FEATURES; f++) begin
        if (accept && (vec_cnt_q == VEC_CNT_BITS'(v)) && (elem_cnt_q == ELEM_CNT_BITS'(f))) begin
          data_d[(v*FEATURES+f)*ELEMENT_BITS +: ELEMENT_BITS] = in_data;
        end
      end
    end

    if (abort) begin
      state_d    = IDLE;
      elem_cnt_d = '0;
      vec_cnt_d  = '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            state_d    = FILL;
            elem_cnt_d = '0;
            vec_cnt_d  = '0;
          end
        end
        FILL: begin
          if (accept) begin
            if (elem_last) begin
              elem_cnt_d = '0;
              if (vec_last) begin
                vec_cnt_d = '0;
                state_d   = HOLD;
                done_d    = 1'b1;
              end else begin
                vec_cnt_d = vec_cnt_q + VEC_CNT_BITS'(1);
              end
            end else begin
              elem_cnt_d = elem_cnt_q + ELEM_CNT_BITS'(1);
            end
          end
        end
        HOLD: begin
          // start together with out_ack chains straight into the next frame
          if (out_ack) begin
            state_d    = start ? FILL : IDLE;
            elem_cnt_d = '0;
            vec_cnt_d  = '0;
          end
        end
        default: begin
          state_d    = IDLE;
          elem_cnt_d = '0;
          vec_cnt_d  = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      elem_cnt_q <= '0;
      vec_cnt_q  <= '0;
      data_q     <= '0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      elem_cnt_q <= elem_cnt_d;
      vec_cnt_q  <= vec_cnt_d;
      data_q     <= data_d;
      done_q     <= done_d;
    end
  end

  assign in_ready  = (state_q == FILL);
  assign out_valid = (state_q == HOLD);
  assign busy      = (state_q != IDLE);
  assign done      = done_q;
  assign out_data  = data_q;

endmodule
